nv_nvdla_hls_shiftrightsat_pipe: RTL and testbench

NV_NVDLA_HLS_SHIFTRIGHTSAT_PIPE -- requirements
Module: NV_NVDLA_HLS_shiftrightsat_pipe

---
 rtl/nv_nvdla_hls_shiftrightsatsu.sv | 32 +++
 rtl/nv_nvdla_hls_shiftrightsat_pipe.sv | 64 ++++++
 tb/tb_nv_nvdla_hls_shiftrightsat_pipe.sv | 249 ++++++++++++++++++++++++
 3 files changed

// File: rtl/nv_nvdla_hls_shiftrightsatsu.sv
// nv_nvdla_hls_shiftrightsatsu: arithmetic right shift with rounding and signed saturation
module nv_nvdla_hls_shiftrightsatsu #(
  parameter int IN_WIDTH    = 49,
  parameter int OUT_WIDTH   = 32,
  parameter int SHIFT_WIDTH = 6
) (
  input  logic [IN_WIDTH-1:0]    data_in,
  input  logic [SHIFT_WIDTH-1:0] shift_num,
  output logic [OUT_WIDTH-1:0]   data_out,
  output logic                   sat_out
);
  localparam logic [OUT_WIDTH-1:0] MAX_VAL = {1'b0, {(OUT_WIDTH-1){1'b1}}};
  localparam logic [OUT_WIDTH-1:0] MIN_VAL = {1'b1, {(OUT_WIDTH-1){1'b0}}};
  logic [IN_WIDTH-1:0] shifted, one_sh, gmask, smask;
  logic [IN_WIDTH:0]   rounded;
  logic                sign, guide, sticky, big, ovf;
  always_comb begin
    sign     = data_in[IN_WIDTH-1];
    shifted  = $signed(data_in) >>> shift_num;
    one_sh   = {{(IN_WIDTH-1){1'b0}}, 1'b1} << shift_num;
    gmask    = one_sh >> 1;
    smask    = gmask - {{(IN_WIDTH-1){1'b0}}, 1'b1};
    guide    = |(data_in & gmask);
    sticky   = |(data_in & smask);
    rounded  = {shifted[IN_WIDTH-1], shifted} + {{IN_WIDTH{1'b0}}, guide & (~sign | sticky)};
    big      = 32'(shift_num) >= IN_WIDTH;
    // any upper bit disagreeing with the result sign means the value left the output range
    ovf      = rounded[IN_WIDTH:OUT_WIDTH-1] != {(IN_WIDTH-OUT_WIDTH+2){rounded[IN_WIDTH]}};
    data_out = big ? '0 : ovf ? (rounded[IN_WIDTH] ? MIN_VAL : MAX_VAL) : rounded[OUT_WIDTH-1:0];
    sat_out  = ~big & ovf;
  end
endmodule

// File: rtl/nv_nvdla_hls_shiftrightsat_pipe.sv
// nv_nvdla_hls_shiftrightsat_pipe: two-stage valid/ready shift-round-saturate pipe with saturation counter
module nv_nvdla_hls_shiftrightsat_pipe #(
  parameter int IN_WIDTH    = 49,
  parameter int OUT_WIDTH   = 32,
  parameter int SHIFT_WIDTH = 6,
  parameter int CNT_WIDTH   = 32
) (
  input  logic                   nvdla_core_clk,
  input  logic                   nvdla_core_rstn,
  input  logic                   acc_pvld,
  output logic                   acc_prdy,
  input  logic [IN_WIDTH-1:0]    acc_pd,
  input  logic [SHIFT_WIDTH-1:0] acc_shift,
  output logic                   cvt_pvld,
  input  logic                   cvt_prdy,
  output logic [OUT_WIDTH-1:0]   cvt_pd,
  output logic                   cvt_sat,
  input  logic                   sat_cnt_clr,
  output logic [CNT_WIDTH-1:0]   sat_cnt
);
  logic                   s1_vld, s2_vld, s2_adv, acc_load, sat_inc, cvt_sat_d;
  logic [IN_WIDTH-1:0]    s1_pd;
  logic [SHIFT_WIDTH-1:0] s1_shift;
  logic [OUT_WIDTH-1:0]   cvt_pd_d;
  always_comb begin
    s2_adv   = s1_vld & (~s2_vld | cvt_prdy);
    acc_prdy = ~s1_vld | s2_adv;
    acc_load = acc_pvld & acc_prdy;
    cvt_pvld = s2_vld;
    sat_inc  = s2_vld & cvt_prdy & cvt_sat;
  end
  nv_nvdla_hls_shiftrightsatsu #(
    .IN_WIDTH(IN_WIDTH), .OUT_WIDTH(OUT_WIDTH), .SHIFT_WIDTH(SHIFT_WIDTH)
  ) u_cvt (
    .data_in(s1_pd), .shift_num(s1_shift), .data_out(cvt_pd_d), .sat_out(cvt_sat_d)
  );
  always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
    if (!nvdla_core_rstn) begin
      s1_vld   <= 1'b0;
      s2_vld   <= 1'b0;
      s1_pd    <= '0;
      s1_shift <= '0;
      cvt_pd   <= '0;
      cvt_sat  <= 1'b0;
    end else begin
      s1_vld <= acc_load | (s1_vld & ~s2_adv);
      s2_vld <= s2_adv | (s2_vld & ~cvt_prdy);
      if (acc_load) begin
        s1_pd    <= acc_pd;
        s1_shift <= acc_shift;
      end
      if (s2_adv) begin
        cvt_pd  <= cvt_pd_d;
        cvt_sat <= cvt_sat_d;
      end
    end
  end
  // clear wins over the old value but still lets a coincident increment count
  always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
    if (!nvdla_core_rstn) sat_cnt <= '0;
    else sat_cnt <= sat_cnt_clr ? CNT_WIDTH'(sat_inc) :
                    (sat_inc & ~&sat_cnt) ? sat_cnt + CNT_WIDTH'(1) : sat_cnt;
  end
endmodule

// File: tb/tb_nv_nvdla_hls_shiftrightsat_pipe.sv
// tb_nv_nvdla_hls_shiftrightsat_pipe: vector table, random scoreboard and corner sequences
module tb_nv_nvdla_hls_shiftrightsat_pipe;
  logic        clk = 0, rstn = 0;
  logic        acc_pvld = 0, cvt_prdy = 0, sat_cnt_clr = 0;
  logic [48:0] acc_pd = '0;
  logic [5:0]  acc_shift = '0;
  logic        acc_prdy, cvt_pvld, cvt_sat, acc_prdy_c, cvt_pvld_c, cvt_sat_c;
  logic [31:0] cvt_pd, cvt_pd_c, sat_cnt;
  logic [2:0]  sat_cnt_c;
  int n_cmp = 0, n_err = 0, n_out = 0;

  typedef struct { logic [31:0] pd; logic sat; } beat_t;
  typedef struct { logic [48:0] acc; logic [5:0] sh; logic [31:0] pd; logic sat; } vec_t;
  beat_t q[$];
  logic [31:0] cnt = 0, prev_pd = 0;
  logic [2:0]  cnt_c = 0;
  logic        prev_stall = 0, prev_sat = 0;

  always #5 clk = ~clk;

  nv_nvdla_hls_shiftrightsat_pipe dut (
    .nvdla_core_clk(clk), .nvdla_core_rstn(rstn), .acc_pvld(acc_pvld), .acc_prdy(acc_prdy),
    .acc_pd(acc_pd), .acc_shift(acc_shift), .cvt_pvld(cvt_pvld), .cvt_prdy(cvt_prdy),
    .cvt_pd(cvt_pd), .cvt_sat(cvt_sat), .sat_cnt_clr(sat_cnt_clr), .sat_cnt(sat_cnt));

  nv_nvdla_hls_shiftrightsat_pipe #(.CNT_WIDTH(3)) dut_c (
    .nvdla_core_clk(clk), .nvdla_core_rstn(rstn), .acc_pvld(acc_pvld), .acc_prdy(acc_prdy_c),
    .acc_pd(acc_pd), .acc_shift(acc_shift), .cvt_pvld(cvt_pvld_c), .cvt_prdy(cvt_prdy),
    .cvt_pd(cvt_pd_c), .cvt_sat(cvt_sat_c), .sat_cnt_clr(sat_cnt_clr), .sat_cnt(sat_cnt_c));

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  // reference: floor division by 2^s, then the remainder decides rounding
  function automatic beat_t ref_conv(input logic [48:0] a, input int s);
    beat_t  b;
    longint v, fl, rem, half, r;
    v = $signed(a);
    b.pd = 0; b.sat = 0;
    if (s >= 49) return b;
    fl   = v >>> s;
    rem  = v - fl * (64'sd1 << s);
    half = (s == 0) ? 0 : (64'sd1 << (s - 1));
    r = fl + ((s > 0 && (rem > half || (rem == half && v >= 0))) ? 1 : 0);
    if (r > 64'sd2147483647)       begin b.pd = 32'h7FFFFFFF; b.sat = 1; end
    else if (r < -64'sd2147483648) begin b.pd = 32'h80000000; b.sat = 1; end
    else b.pd = r[31:0];
    return b;
  endfunction

  always @(negedge clk) begin
    beat_t e;
    logic  inc;
    if (!rstn) begin
      q.delete(); cnt = 0; cnt_c = 0; prev_stall = 0;
    end else begin
      check("acc_prdy", acc_prdy, !(q.size() == 2 && !cvt_prdy));
      check("sat_cnt", sat_cnt, cnt);
      check("sat_cnt_small", sat_cnt_c, cnt_c);
      if (prev_stall) begin
        check("stall_vld", cvt_pvld, 1);
        check("stall_pd", cvt_pd, prev_pd);
        check("stall_sat", cvt_sat, prev_sat);
      end
      inc = 0;
      if (cvt_pvld && cvt_prdy) begin
        n_out++;
        if (q.size() == 0) begin
          n_cmp++; n_err++;
          $display("FAIL unexpected_beat: got pd %0h with no beat outstanding", cvt_pd);
        end else begin
          e = q.pop_front();
          check("sb_pd", cvt_pd, e.pd);
          check("sb_sat", cvt_sat, e.sat);
          inc = e.sat;
        end
      end
      if (sat_cnt_clr) begin cnt = {31'd0, inc}; cnt_c = {2'd0, inc}; end
      else if (inc) begin
        if (cnt != 32'hFFFFFFFF) cnt = cnt + 1;
        if (cnt_c != 3'h7) cnt_c = cnt_c + 1;
      end
      prev_stall = cvt_pvld && !cvt_prdy; prev_pd = cvt_pd; prev_sat = cvt_sat;
      if (acc_pvld && acc_prdy) q.push_back(ref_conv(acc_pd, int'(acc_shift)));
    end
  end

  task automatic drain();
    acc_pvld = 0; cvt_prdy = 1;
    for (int i = 0; i < 20 && q.size() != 0; i++) @(posedge clk) #1;
    @(posedge clk) #1;
    check("drain_empty", q.size(), 0);
  endtask

  vec_t vt[17];
  initial begin
    vt[0]  = '{49'h0_0000_0000_0180, 6'd8,  32'h00000002, 1'b0};
    vt[1]  = '{49'h1_FFFF_FFFF_FE80, 6'd8,  32'hFFFFFFFE, 1'b0};
    vt[2]  = '{49'h0_0100_0000_0000, 6'd4,  32'h7FFFFFFF, 1'b1};
    vt[3]  = '{49'h1_2345_6789_ABCD, 6'd49, 32'h00000000, 1'b0};
    vt[4]  = '{49'h1_FFFF_FFFF_FFFF, 6'd63, 32'h00000000, 1'b0};
    vt[5]  = '{49'h0_0000_7FFF_FFFF, 6'd0,  32'h7FFFFFFF, 1'b0};
    vt[6]  = '{49'h0_0000_8000_0000, 6'd0,  32'h7FFFFFFF, 1'b1};
    vt[7]  = '{49'h1_FFFF_8000_0000, 6'd0,  32'h80000000, 1'b0};
    vt[8]  = '{49'h1_FFFF_7FFF_FFFF, 6'd0,  32'h80000000, 1'b1};
    vt[9]  = '{49'h0_0000_FFFF_FFFF, 6'd1,  32'h7FFFFFFF, 1'b1};
    vt[10] = '{49'h1_FFFF_FFFF_FFFF, 6'd1,  32'hFFFFFFFF, 1'b0};
    vt[11] = '{49'h1_FFFF_FFFF_FFFB, 6'd1,  32'hFFFFFFFD, 1'b0};
    vt[12] = '{49'h1_FFFF_FFFF_FFF9, 6'd2,  32'hFFFFFFFE, 1'b0};
    vt[13] = '{49'h1_FFFF_FFFF_FFFB, 6'd2,  32'hFFFFFFFF, 1'b0};
    vt[14] = '{49'h0_0000_0000_0005, 6'd2,  32'h00000001, 1'b0};
    vt[15] = '{49'h0_8000_0000_0000, 6'd48, 32'h00000001, 1'b0};
    vt[16] = '{49'h1_0000_0000_0000, 6'd48, 32'hFFFFFFFF, 1'b0};

    #1;
    check("rst_pvld", cvt_pvld, 0);
    check("rst_pd", cvt_pd, 0);
    check("rst_sat", cvt_sat, 0);
    check("rst_cnt", sat_cnt, 0);
    repeat (3) @(posedge clk);
    #2 rstn = 1;
    #1 check("rel_prdy", acc_prdy, 1);

    // isolated table vectors, two-cycle latency
    cvt_prdy = 1;
    for (int i = 0; i < 17; i++) begin
      logic [31:0] c0;
      @(posedge clk) #1;
      c0 = sat_cnt;
      acc_pvld = 1; acc_pd = vt[i].acc; acc_shift = vt[i].sh;
      @(posedge clk) #1;
      acc_pvld = 0;
      check("tbl_lat1", cvt_pvld, 0);
      @(posedge clk) #1;
      check("tbl_vld", cvt_pvld, 1);
      check("tbl_pd", cvt_pd, vt[i].pd);
      check("tbl_sat", cvt_sat, vt[i].sat);
      @(posedge clk) #1;
      check("tbl_cnt", sat_cnt, c0 + {31'd0, vt[i].sat});
    end
    drain();

    // randomized traffic
    for (int i = 0; i < 2000; i++) begin
      int s, sel;
      @(posedge clk) #1;
      cvt_prdy = ($urandom_range(0, 3) != 0);
      sat_cnt_clr = ($urandom_range(0, 63) == 0);
      acc_pvld = ($urandom_range(0, 3) != 0);
      s = ($urandom_range(0, 7) == 0) ? $urandom_range(49, 63) : $urandom_range(0, 48);
      sel = $urandom_range(0, 3);
      acc_shift = 6'(s);
      case (sel)
        0: acc_pd = 49'({$urandom, $urandom});
        1: acc_pd = 49'($signed(16'($urandom)));
        2: acc_pd = 49'($signed(32'($urandom))) << (s < 49 ? s : 0);
        default: acc_pd = (49'($urandom_range(0, 255)) << s) | ((s > 0 && s < 49) ? (49'd1 << (s - 1)) : 49'd0);
      endcase
    end
    sat_cnt_clr = 0;
    drain();

    // 8 beats back to back with ready toggling every cycle
    begin
      int sent, o0, cyc;
      logic hs;
      sent = 0; cyc = 0; o0 = n_out;
      @(posedge clk) #1;
      cvt_prdy = 0;
      acc_pvld = 1; acc_pd = 49'($signed(32'($urandom))) << 3; acc_shift = 6'd2;
      while (sent < 8 && cyc < 100) begin
        @(negedge clk) hs = acc_prdy;
        @(posedge clk) #1;
        cyc++;
        cvt_prdy = ~cvt_prdy;
        if (hs) begin
          sent++;
          acc_pd = 49'($signed(32'($urandom))) << 3;
          acc_pvld = (sent < 8);
        end
      end
      check("toggle_sent", sent, 8);
      drain();
      check("toggle_out", n_out - o0, 8);
    end

    // reset with both stages full
    @(posedge clk) #1;
    cvt_prdy = 0; acc_pvld = 1; acc_pd = 49'h0_0100_0000_0000; acc_shift = 6'd4;
    repeat (4) @(posedge clk) #1;
    acc_pvld = 0;
    check("full_q", q.size(), 2);
    check("full_prdy", acc_prdy, 0);
    #1 rstn = 0;
    #1;
    check("arst_pvld", cvt_pvld, 0);
    check("arst_cnt", sat_cnt, 0);
    check("arst_pd", cvt_pd, 0);
    check("arst_prdy", acc_prdy, 1);
    @(posedge clk);
    #2 rstn = 1;
    @(posedge clk) #1;
    check("post_prdy", acc_prdy, 1);
    cvt_prdy = 1; acc_pvld = 1; acc_pd = 49'h0_0000_0000_0180; acc_shift = 6'd8;
    @(posedge clk) #1;
    acc_pvld = 0;
    check("post_lat1", cvt_pvld, 0);
    @(posedge clk) #1;
    check("post_vld", cvt_pvld, 1);
    check("post_pd", cvt_pd, 32'h2);
    drain();

    // small counter sticks at all-ones, then clear with coincident increment
    acc_pvld = 1; acc_pd = 49'h0_0100_0000_0000; acc_shift = 6'd4;
    repeat (9) @(posedge clk) #1;
    acc_pvld = 0;
    drain();
    check("stick_small", sat_cnt_c, 3'h7);
    check("cnt_nine", sat_cnt, 32'd9);
    acc_pvld = 1;
    @(posedge clk) #1;
    acc_pvld = 0;
    @(posedge clk) #1;
    sat_cnt_clr = 1;
    @(posedge clk) #1;
    sat_cnt_clr = 0;
    check("clr_inc", sat_cnt, 1);
    check("clr_inc_small", sat_cnt_c, 1);
    sat_cnt_clr = 1;
    @(posedge clk) #1;
    sat_cnt_clr = 0;
    check("clr_only", sat_cnt, 0);
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end
endmodule
